// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes, ID width and payload typedefs for the
// register file and its bus interface.
package axi4_lite_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam int         AXI_ID_W        = 4;

  typedef logic [31:0]         axi4_lite_data_t;
  typedef logic [3:0]          axi4_lite_strb_t;
  typedef logic [AXI_ID_W-1:0] axi4_lite_id_t;
endpackage

// File: rtl/axi4_if.sv
// AXI4-Lite channel bundle (single-beat subset) with a slave-side modport.
interface axi4_if
  import axi4_lite_pkg::*;
#(
  parameter int A = 32
);
  axi4_lite_id_t   awid;
  logic [A-1:0]    awaddr;
  logic            awvalid;
  logic            awready;
  axi4_lite_data_t wdata;
  axi4_lite_strb_t wstrb;
  logic            wvalid;
  logic            wready;
  axi4_lite_id_t   bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  axi4_lite_id_t   arid;
  logic [A-1:0]    araddr;
  logic            arvalid;
  logic            arready;
  axi4_lite_id_t   rid;
  axi4_lite_data_t rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport slave (
    input  awid, awaddr, awvalid, wdata, wstrb, wvalid, bready,
           arid, araddr, arvalid, rready,
    output awready, wready, bid, bresp, bvalid,
           arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_lite_hold_reg.sv
// One-entry holding register: absorbs a beat when empty and presents it
// (or the live input) until the consumer takes it.
module axi4_lite_hold_reg #(
  parameter int W = 8
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         take,
  output logic         avail,
  output logic [W-1:0] out_data
);
  logic         held;
  logic [W-1:0] q;

  assign in_ready = ~held;
  assign avail    = held | in_valid;
  assign out_data = held ? q : in_data;

  // A take while empty consumes the live beat directly, so nothing is latched.
  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      held <= 1'b0;
      q    <= '0;
    end else if (take) begin
      held <= 1'b0;
    end else if (in_valid && !held) begin
      held <= 1'b1;
      q    <= in_data;
    end
  end
endmodule

// File: rtl/axi4_lite_register_file.sv
// AXI4-Lite slave exposing N 32-bit control registers as flat outputs, with a
// one-cycle per-register write strobe.
module axi4_lite_register_file
  import axi4_lite_pkg::*;
#(
  parameter int N = 16,
  parameter int A = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  axi4_if.slave               axi4_s,
  output logic [N-1:0][31:0]  reg_q,
  output logic [N-1:0]        wr_stb
);
  localparam int IW  = $clog2(N);
  localparam int AWP = AXI_ID_W + A;
  localparam int WP  = 32 + 4;

  logic [AWP-1:0]  aw_pl;
  logic [WP-1:0]   w_pl;
  logic            aw_avail, w_avail, commit;
  axi4_lite_id_t   aw_id;
  logic [A-1:0]    aw_addr;
  axi4_lite_data_t w_data;
  axi4_lite_strb_t w_strb;
  logic            aw_oor, ar_oor, ar_fire;
  logic [IW-1:0]   aw_idx, ar_idx;
  logic            unused_addr_lsbs;

  logic            bvalid, rvalid, rlast;
  axi4_lite_id_t   bid, rid;
  logic [1:0]      bresp, rresp;
  axi4_lite_data_t rdata;

  axi4_lite_hold_reg #(.W(AWP)) u_aw_hold (
    .gclk     (aclk),
    .grst_n   (aresetn),
    .in_valid (axi4_s.awvalid),
    .in_ready (axi4_s.awready),
    .in_data  ({axi4_s.awid, axi4_s.awaddr}),
    .take     (commit),
    .avail    (aw_avail),
    .out_data (aw_pl)
  );

  axi4_lite_hold_reg #(.W(WP)) u_w_hold (
    .gclk     (aclk),
    .grst_n   (aresetn),
    .in_valid (axi4_s.wvalid),
    .in_ready (axi4_s.wready),
    .in_data  ({axi4_s.wdata, axi4_s.wstrb}),
    .take     (commit),
    .avail    (w_avail),
    .out_data (w_pl)
  );

  assign {aw_id, aw_addr} = aw_pl;
  assign {w_data, w_strb} = w_pl;

  assign aw_oor  = |aw_addr[A-1:IW+2];
  assign aw_idx  = aw_addr[IW+1:2];
  assign ar_oor  = |axi4_s.araddr[A-1:IW+2];
  assign ar_idx  = axi4_s.araddr[IW+1:2];
  assign unused_addr_lsbs = ^{aw_addr[1:0], axi4_s.araddr[1:0]};

  assign commit  = aw_avail & w_avail & (~bvalid | axi4_s.bready);
  assign axi4_s.arready = ~rvalid | axi4_s.rready;
  assign ar_fire = axi4_s.arvalid & axi4_s.arready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      reg_q  <= '0;
      wr_stb <= '0;
      bvalid <= 1'b0;
      bid    <= '0;
      bresp  <= AXI_RESP_OKAY;
    end else begin
      wr_stb <= '0;
      if (bvalid && axi4_s.bready) bvalid <= 1'b0;
      if (commit) begin
        bvalid <= 1'b1;
        bid    <= aw_id;
        if (aw_oor) begin
          bresp <= AXI_RESP_SLVERR;
        end else begin
          bresp          <= AXI_RESP_OKAY;
          wr_stb[aw_idx] <= 1'b1;
          for (int b = 0; b < 4; b++)
            if (w_strb[b]) reg_q[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  // Reads sample reg_q before any same-edge commit lands: pre-write value.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rvalid <= 1'b0;
      rid    <= '0;
      rdata  <= '0;
      rresp  <= AXI_RESP_OKAY;
      rlast  <= 1'b0;
    end else begin
      if (rvalid && axi4_s.rready) rvalid <= 1'b0;
      if (ar_fire) begin
        rvalid <= 1'b1;
        rid    <= axi4_s.arid;
        rlast  <= 1'b1;
        rdata  <= ar_oor ? '0 : reg_q[ar_idx];
        rresp  <= ar_oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
    end
  end

  assign axi4_s.bvalid = bvalid;
  assign axi4_s.bid    = bid;
  assign axi4_s.bresp  = bresp;
  assign axi4_s.rvalid = rvalid;
  assign axi4_s.rid    = rid;
  assign axi4_s.rdata  = rdata;
  assign axi4_s.rresp  = rresp;
  assign axi4_s.rlast  = rlast;
endmodule

// File: tb/tb_axi4_lite_register_file.sv
// Directed bench for axi4_lite_register_file: B/R responses checked against a
// scoreboard fed from a small register model, plus direct state checks.
module tb_axi4_lite_register_file;
  import axi4_lite_pkg::*;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi4_if #(.A(32)) bus();
  logic [15:0][31:0] reg_q;
  logic [15:0]       wr_stb;

  axi4_lite_register_file #(.N(16), .A(32)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axi4_s  (bus),
    .reg_q   (reg_q),
    .wr_stb  (wr_stb)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;

  rsp_t        b_q[$];
  rsp_t        r_q[$];
  logic [31:0] model[16];
  int          stb_cnt[16];
  int          stb_total = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail(string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed event with no expectation or timeout", tag);
  endtask

  always @(negedge aclk) begin
    rsp_t e;
    if (aresetn) begin
      for (int i = 0; i < 16; i++)
        if (wr_stb[i]) begin stb_cnt[i]++; stb_total++; end
      if (bus.bvalid && bus.bready) begin
        if (b_q.size() == 0) fail("b_unexpected");
        else begin
          e = b_q.pop_front();
          chk("b_id", 64'(bus.bid), 64'(e.id));
          chk("b_resp", 64'(bus.bresp), 64'(e.resp));
        end
      end
      if (bus.rvalid && bus.rready) begin
        if (r_q.size() == 0) fail("r_unexpected");
        else begin
          e = r_q.pop_front();
          chk("r_id", 64'(bus.rid), 64'(e.id));
          chk("r_data", 64'(bus.rdata), 64'(e.data));
          chk("r_resp", 64'(bus.rresp), 64'(e.resp));
          chk("r_last", 64'(bus.rlast), 64'd1);
        end
      end
    end
  end

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic send_aw(logic [3:0] id, logic [31:0] addr);
    logic fire;
    bus.awid = id; bus.awaddr = addr; bus.awvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk); fire = bus.awready;
      @(posedge aclk); #1;
      if (fire) begin bus.awvalid = 1'b0; return; end
    end
    bus.awvalid = 1'b0;
    fail("aw_timeout");
  endtask

  task automatic send_w(logic [31:0] data, logic [3:0] strb);
    logic fire;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk); fire = bus.wready;
      @(posedge aclk); #1;
      if (fire) begin bus.wvalid = 1'b0; return; end
    end
    bus.wvalid = 1'b0;
    fail("w_timeout");
  endtask

  task automatic send_ar(logic [3:0] id, logic [31:0] addr);
    logic fire;
    bus.arid = id; bus.araddr = addr; bus.arvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk); fire = bus.arready;
      @(posedge aclk); #1;
      if (fire) begin bus.arvalid = 1'b0; return; end
    end
    bus.arvalid = 1'b0;
    fail("ar_timeout");
  endtask

  task automatic wr(logic [3:0] id, logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
    logic oor = (addr >= 32'd64);
    b_q.push_back('{id: id, data: 32'd0, resp: oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY});
    fork
      send_aw(id, addr);
      send_w(data, strb);
    join
    if (!oor) model[addr[5:2]] = merge(model[addr[5:2]], data, strb);
  endtask

  task automatic rd(logic [3:0] id, logic [31:0] addr);
    logic oor = (addr >= 32'd64);
    r_q.push_back('{id: id, data: oor ? 32'd0 : model[addr[5:2]],
                    resp: oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY});
    send_ar(id, addr);
  endtask

  task automatic step();
    @(posedge aclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    for (int i = 0; i < 16; i++) begin model[i] = '0; stb_cnt[i] = 0; end
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    bus.awid = 0; bus.awaddr = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.arid = 0; bus.araddr = 0; bus.bready = 1; bus.rready = 1;

    // Reset, then a W beat gets held and a second reset must discard it
    repeat (2) step();
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_reg_q", 64'(|reg_q), 64'd0);
    chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_readys", 64'({bus.awready, bus.wready, bus.arready}), 64'h7);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    step();
    bus.wdata = 32'hAAAA_AAAA; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    step();
    bus.wvalid = 1'b0;
    aresetn = 1'b0;
    repeat (2) step();
    aresetn = 1'b1;
    @(negedge aclk);
    chk("midrst_wready", 64'(bus.wready), 64'd1);
    chk("midrst_bvalid", 64'(bus.bvalid), 64'd0);
    chk("midrst_stb", 64'(stb_total), 64'd0);
    chk("midrst_reg_q", 64'(|reg_q), 64'd0);
    step();

    // AW and W together
    wr(4'd1, 32'h08, 32'hDEAD_BEEF, 4'hF);
    @(negedge aclk);
    chk("t2_bvalid", 64'(bus.bvalid), 64'd1);
    chk("t2_reg2", 64'(reg_q[2]), 64'hDEAD_BEEF);
    chk("t2_stb", 64'(wr_stb), 64'h0004);
    step();
    @(negedge aclk);
    chk("t2_stb_drop", 64'(wr_stb), 64'd0);
    chk("t2_stb_cnt", 64'(stb_cnt[2]), 64'd1);
    step();

    // W leads AW by three cycles
    b_q.push_back('{id: 4'd2, data: 32'd0, resp: AXI_RESP_OKAY});
    send_w(32'h1234_5678, 4'h3);
    @(negedge aclk);
    chk("t3_wready_low", 64'(bus.wready), 64'd0);
    chk("t3_no_commit", 64'(reg_q[2]), 64'hDEAD_BEEF);
    repeat (2) step();
    send_aw(4'd2, 32'h08);
    model[2] = merge(model[2], 32'h1234_5678, 4'h3);
    @(negedge aclk);
    chk("t3_reg2", 64'(reg_q[2]), 64'hDEAD_5678);
    chk("t3_stb", 64'(wr_stb), 64'h0004);
    step();

    // B stalled: one more AW/W absorbed, then readys drop
    bus.bready = 1'b0;
    wr(4'd3, 32'h0C, 32'h1111_1111, 4'hF);
    wr(4'd4, 32'h10, 32'h2222_2222, 4'hF);
    @(negedge aclk);
    chk("t4_awready", 64'(bus.awready), 64'd0);
    chk("t4_wready", 64'(bus.wready), 64'd0);
    chk("t4_bid_held", 64'(bus.bid), 64'd3);
    chk("t4_reg4_pending", 64'(reg_q[4]), 64'd0);
    step();
    bus.bready = 1'b1;
    step();
    @(negedge aclk);
    chk("t4_reg4", 64'(reg_q[4]), 64'h2222_2222);
    chk("t4_stb", 64'(wr_stb), 64'h0010);
    step();

    // Out of range read and write
    rd(4'd5, 32'h40);
    saved = stb_total;
    wr(4'd6, 32'h40, 32'hFFFF_FFFF, 4'hF);
    step();
    @(negedge aclk);
    chk("t5_no_stb", 64'(stb_total), 64'(saved));
    for (int i = 0; i < 16; i++) chk($sformatf("t5_reg%0d", i), 64'(reg_q[i]), 64'(model[i]));
    step();

    // Four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      bus.arid = 4'(8 + i); bus.araddr = 32'(4 * i); bus.arvalid = 1'b1;
      r_q.push_back('{id: 4'(8 + i), data: model[i], resp: AXI_RESP_OKAY});
      @(negedge aclk);
      chk($sformatf("t6_arready%0d", i), 64'(bus.arready), 64'd1);
      step();
    end
    bus.arvalid = 1'b0;
    step();
    @(negedge aclk);
    chk("t6_r_drained", 64'(r_q.size()), 64'd0);
    step();

    // R stalled for two cycles
    bus.rready = 1'b0;
    rd(4'd12, 32'h08);
    bus.arvalid = 1'b1; bus.arid = 4'd13; bus.araddr = 32'h0C;
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      chk("t6_stall_arready", 64'(bus.arready), 64'd0);
      chk("t6_stall_rdata", 64'(bus.rdata), 64'(model[2]));
      chk("t6_stall_rid", 64'(bus.rid), 64'd12);
      step();
    end
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    step();

    // Same-edge read and write to one index returns the old value
    fork
      rd(4'd14, 32'h0C);
      wr(4'd15, 32'h0C, 32'hCAFE_F00D, 4'hF);
    join
    repeat (3) step();
    @(negedge aclk);
    chk("t7_reg3", 64'(reg_q[3]), 64'hCAFE_F00D);
    chk("end_b_q", 64'(b_q.size()), 64'd0);
    chk("end_r_q", 64'(r_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
